// File: rtl/ets_pkg.sv
// ets_pkg: shared state encoding and opcode field constants
// for the instruction tracker front-end of ets_monitor.
package ets_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int OPC_LSB = 0;
  localparam int OPC_W   = 7;

endpackage

// File: rtl/ets_instr_tracker_if.sv
// ets_instr_tracker_if: core issue/retire/flush event bundle.
// master = core side (drives), slave = tracker side (receives).
interface ets_instr_tracker_if;

  logic        core_issue_valid;
  logic [31:0] core_issue_pc;
  logic [31:0] core_issue_instr;
  logic        core_retire_valid;
  logic        core_flush;

  modport master (
    output core_issue_valid,
    output core_issue_pc,
    output core_issue_instr,
    output core_retire_valid,
    output core_flush
  );

  modport slave (
    input core_issue_valid,
    input core_issue_pc,
    input core_issue_instr,
    input core_retire_valid,
    input core_flush
  );

endinterface

// File: rtl/ets_sat_counter.sv
// ets_sat_counter: W-bit event counter, saturates at all-ones.
// Ports: clk, rst (async high), inc, clr (sync, wins), count.
module ets_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && count != '1) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ets_instr_tracker.sv
// ets_instr_tracker: turns core issue/retire/flush events into a
// start/active/done window with latched pc/opcode, plus stats.
// Ports: clk, rst (async high), en, clr_stats, core (slave),
// instr_* window outputs, trk_* status and counters.
module ets_instr_tracker
  import ets_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr_stats,
  ets_instr_tracker_if.slave core,
  output logic               instr_start,
  output logic               instr_active,
  output logic               instr_done,
  output logic [31:0]        instr_pc,
  output logic [OPC_W-1:0]   instr_opcode,
  output logic               trk_busy,
  output logic               trk_timeout,
  output logic [31:0]        trk_count,
  output logic [CNT_W-1:0]   trk_dropped,
  output logic [CNT_W-1:0]   trk_aborted
);

  localparam int WW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT_CYCLES - 1);

  state_e        state_q;
  state_e        state_d;
  logic          pend_q;
  logic [WW-1:0] wait_q;

  logic in_open;
  logic can_acc;
  logic issue_ok;
  logic accept;
  logic drop;
  logic abort;
  logic tmo_hit;
  logic tmo_set;
  logic done_inc;
  logic retire;
  logic flush;

  logic unused_instr;
  assign unused_instr = ^core.core_issue_instr;

  assign retire   = core.core_retire_valid;
  assign flush    = core.core_flush;
  assign in_open  = (state_q == START) || (state_q == ACTIVE);
  assign can_acc  = (state_q == IDLE) || (state_q == DONE);
  assign issue_ok = en && core.core_issue_valid && !flush;
  assign accept   = issue_ok && can_acc;
  assign drop     = issue_ok && in_open;
  assign abort    = flush && in_open;
  assign tmo_hit  = (state_q == ACTIVE) && (wait_q == WLAST);
  assign tmo_set  = tmo_hit && !retire && !flush;
  assign done_inc = (state_d == DONE) && (state_q != DONE);

  // Flush is checked first so it beats retire and timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = START;
      end
      START: begin
        if (flush)                 state_d = IDLE;
        else if (retire || pend_q) state_d = DONE;
        else                       state_d = ACTIVE;
      end
      ACTIVE: begin
        if (flush)                  state_d = IDLE;
        else if (retire || tmo_hit) state_d = DONE;
      end
      DONE: begin
        state_d = accept ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_q       <= 1'b0;
      wait_q       <= '0;
      instr_pc     <= '0;
      instr_opcode <= '0;
      trk_timeout  <= 1'b0;
    end else begin
      state_q <= state_d;
      // A retire alongside the accepted issue belongs to it.
      if (accept) begin
        pend_q       <= retire;
        instr_pc     <= core.core_issue_pc;
        instr_opcode <= core.core_issue_instr[OPC_LSB +: OPC_W];
      end else if (state_q == START) begin
        pend_q <= 1'b0;
      end
      if (state_d == START) begin
        wait_q <= '0;
      end else if (state_q == ACTIVE && state_d == ACTIVE) begin
        wait_q <= wait_q + 1'b1;
      end
      if (clr_stats) begin
        trk_timeout <= 1'b0;
      end else if (tmo_set) begin
        trk_timeout <= 1'b1;
      end
    end
  end

  assign instr_start  = (state_q == START);
  assign instr_active = (state_q != IDLE);
  assign instr_done   = (state_q == DONE);
  assign trk_busy     = (state_q != IDLE);

  ets_sat_counter #(.W(32)) u_cnt_done (
    .clk   (clk),
    .rst   (rst),
    .inc   (done_inc),
    .clr   (clr_stats),
    .count (trk_count)
  );

  ets_sat_counter #(.W(CNT_W)) u_cnt_drop (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop),
    .clr   (clr_stats),
    .count (trk_dropped)
  );

  ets_sat_counter #(.W(CNT_W)) u_cnt_abort (
    .clk   (clk),
    .rst   (rst),
    .inc   (abort),
    .clr   (clr_stats),
    .count (trk_aborted)
  );

endmodule

// File: tb/tb_ets_instr_tracker.sv
// tb_ets_instr_tracker: directed bench for ets_instr_tracker,
// TIMEOUT_CYCLES=8, inputs driven and outputs sampled #1 after posedge.
module tb_ets_instr_tracker;

  logic        clk;
  logic        rst;
  logic        en;
  logic        clr_stats;
  logic        instr_start;
  logic        instr_active;
  logic        instr_done;
  logic [31:0] instr_pc;
  logic [6:0]  instr_opcode;
  logic        trk_busy;
  logic        trk_timeout;
  logic [31:0] trk_count;
  logic [15:0] trk_dropped;
  logic [15:0] trk_aborted;

  int checks = 0;
  int passed = 0;

  ets_instr_tracker_if core_if ();

  ets_instr_tracker #(
    .TIMEOUT_CYCLES (8),
    .CNT_W          (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .clr_stats    (clr_stats),
    .core         (core_if.slave),
    .instr_start  (instr_start),
    .instr_active (instr_active),
    .instr_done   (instr_done),
    .instr_pc     (instr_pc),
    .instr_opcode (instr_opcode),
    .trk_busy     (trk_busy),
    .trk_timeout  (trk_timeout),
    .trk_count    (trk_count),
    .trk_dropped  (trk_dropped),
    .trk_aborted  (trk_aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    core_if.core_issue_valid  = 1'b0;
    core_if.core_issue_pc     = '0;
    core_if.core_issue_instr  = '0;
    core_if.core_retire_valid = 1'b0;
    core_if.core_flush        = 1'b0;
  endtask

  task automatic issue(input logic [31:0] pc,
                       input logic [31:0] instr);
    core_if.core_issue_valid = 1'b1;
    core_if.core_issue_pc    = pc;
    core_if.core_issue_instr = instr;
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    clr_stats = 1'b0;
    quiet();
    tick();
    tick();
    check("rst_active", instr_active, 0);
    check("rst_busy", trk_busy, 0);
    check("rst_pc", instr_pc, 0);
    check("rst_count", trk_count, 0);
    rst = 1'b0;
    en  = 1'b1;
    tick();

    // ADDI at 0x100, retire 4 cycles after issue
    issue(32'h100, 32'h00500093);
    tick();
    quiet();
    check("t1_start", instr_start, 1);
    check("t1_active", instr_active, 1);
    check("t1_pc", instr_pc, 32'h100);
    check("t1_opc", instr_opcode, 7'h13);
    tick();
    check("t1_start_pulse", instr_start, 0);
    check("t1_act2", instr_active, 1);
    tick();
    tick();
    core_if.core_retire_valid = 1'b1;
    check("t1_nodone_early", instr_done, 0);
    tick();
    quiet();
    check("t1_done", instr_done, 1);
    check("t1_act5", instr_active, 1);
    check("t1_count", trk_count, 1);
    tick();
    check("t1_idle", instr_active, 0);
    check("t1_done_pulse", instr_done, 0);

    // issue and retire in the same cycle
    issue(32'h200, 32'h00000033);
    core_if.core_retire_valid = 1'b1;
    tick();
    quiet();
    check("t2_start", instr_start, 1);
    check("t2_nodone", instr_done, 0);
    tick();
    check("t2_done", instr_done, 1);
    check("t2_nostart", instr_start, 0);
    tick();
    check("t2_idle", instr_active, 0);
    check("t2_count", trk_count, 2);

    // back-to-back: retire + new issue in the done cycle
    issue(32'h300, 32'h0000006f);
    tick();
    quiet();
    check("t3_opc_a", instr_opcode, 7'h6f);
    tick();
    core_if.core_retire_valid = 1'b1;
    tick();
    check("t3_done_a", instr_done, 1);
    issue(32'h104, 32'h00a00113);
    core_if.core_retire_valid = 1'b1;
    tick();
    quiet();
    check("t3_start_b", instr_start, 1);
    check("t3_nogap", instr_active, 1);
    check("t3_pc_b", instr_pc, 32'h104);
    tick();
    check("t3_done_b", instr_done, 1);
    tick();
    check("t3_count", trk_count, 4);

    // extra issues while busy, then flush
    issue(32'h400, 32'h00002003);
    tick();
    check("t4_opc", instr_opcode, 7'h03);
    issue(32'h404, 32'h00000013);
    tick();
    tick();
    tick();
    core_if.core_flush = 1'b1;
    tick();
    quiet();
    check("t4_abort_act", instr_active, 0);
    check("t4_abort_done", instr_done, 0);
    check("t4_dropped", trk_dropped, 3);
    check("t4_aborted", trk_aborted, 1);
    check("t4_count", trk_count, 4);
    en = 1'b0;
    issue(32'h408, 32'h00000013);
    tick();
    quiet();
    en = 1'b1;
    check("t4_en_off_busy", trk_busy, 0);
    check("t4_en_off_drop", trk_dropped, 3);

    // timeout: no retire
    issue(32'h500, 32'h00000063);
    tick();
    quiet();
    check("t5_start", instr_start, 1);
    for (int i = 0; i < 8; i++) tick();
    check("t5_wait", instr_done, 0);
    check("t5_no_tmo", trk_timeout, 0);
    tick();
    check("t5_done", instr_done, 1);
    check("t5_tmo", trk_timeout, 1);
    check("t5_count", trk_count, 5);
    tick();
    check("t5_idle", instr_active, 0);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("t5_clr_tmo", trk_timeout, 0);
    check("t5_clr_cnt", trk_count, 0);
    check("t5_clr_drop", trk_dropped, 0);
    check("t5_clr_abort", trk_aborted, 0);

    // reset mid-window
    issue(32'h600, 32'h00000013);
    tick();
    quiet();
    tick();
    check("t6_pre_act", instr_active, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_act", instr_active, 0);
    check("t6_rst_done", instr_done, 0);
    check("t6_rst_pc", instr_pc, 0);
    check("t6_rst_busy", trk_busy, 0);
    tick();
    rst = 1'b0;
    tick();
    issue(32'h700, 32'h00000037);
    tick();
    quiet();
    check("t6_start", instr_start, 1);
    check("t6_pc", instr_pc, 32'h700);
    check("t6_opc", instr_opcode, 7'h37);
    core_if.core_retire_valid = 1'b1;
    tick();
    quiet();
    check("t6_done", instr_done, 1);
    check("t6_count", trk_count, 1);
    tick();
    check("t6_idle", instr_active, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
